// File: rtl/mel_pkg.sv
// Shared types and sizes for the mel-band output path: frame geometry, sample/frame types, serializer states.
package mel_pkg;

    localparam int O_BW       = 14;
    localparam int N_BANDS    = 64;
    localparam int GROUP_W    = 7;
    localparam int BAND_IDX_W = $clog2(N_BANDS);

    typedef logic signed [O_BW-1:0]         mel_sample_t;
    typedef logic        [O_BW*N_BANDS-1:0] mel_frame_t;
    typedef logic        [GROUP_W-1:0]      mel_group_t;
    typedef logic        [BAND_IDX_W-1:0]   mel_band_idx_t;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } ser_state_e;

    function automatic mel_sample_t band_of(input mel_frame_t f, input mel_band_idx_t k);
        return mel_sample_t'(f[O_BW*k +: O_BW]);
    endfunction

endpackage

// File: rtl/mel_frame_buf.sv
// Two-slot frame buffer: captures a whole frame per write, exposes the oldest frame; one-cycle write-to-visible.
// A write into a full buffer is dropped (overflow pulse) unless the head frame completes in that same cycle.
module mel_frame_buf
    import mel_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en_i,
    input  mel_frame_t wr_frame_i,
    input  mel_group_t wr_group_i,
    input  logic       rd_done_i,
    output mel_frame_t head_frame_o,
    output mel_group_t head_group_o,
    output logic       next_vld_o,
    output logic [1:0] cnt_o,
    output logic       overflow_o
);

    mel_frame_t frame_q [2];
    mel_group_t group_q [2];
    logic [1:0] vld_q, vld_d;
    logic [1:0] cnt_q, cnt_d;
    logic       wp_q, wp_d;
    logic       rp_q, rp_d;
    logic       ovf_q, ovf_d;
    logic       wr_ok;

    always_comb begin
        wr_ok = wr_en_i && ((cnt_q != 2'd2) || rd_done_i);
        vld_d = vld_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        ovf_d = wr_en_i && !wr_ok;
        // Clear before set: when full, the freed slot is the one being refilled.
        if (rd_done_i) begin
            vld_d[rp_q] = 1'b0;
            rp_d        = ~rp_q;
        end
        if (wr_ok) begin
            vld_d[wp_q] = 1'b1;
            wp_d        = ~wp_q;
        end
        cnt_d = cnt_q + {1'b0, wr_ok} - {1'b0, rd_done_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            cnt_q <= '0;
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            frame_q[wp_q] <= wr_frame_i;
            group_q[wp_q] <= wr_group_i;
        end
    end

    assign head_frame_o = frame_q[rp_q];
    assign head_group_o = group_q[rp_q];
    assign next_vld_o   = vld_q[~rp_q];
    assign cnt_o        = cnt_q;
    assign overflow_o   = ovf_q;

endmodule

// File: rtl/mel_band_serializer.sv
// Streams buffered mel frames one band per cycle with frame/band tags; band 0 appears the cycle after capture.
// Outputs hold while o_ready is low; consecutive buffered frames stream with no bubble.
module mel_band_serializer
    import mel_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [O_BW*N_BANDS-1:0]     data_i,
    input  logic                        di_en,
    input  logic [GROUP_W-1:0]          in_group_num,
    output logic signed [O_BW-1:0]      data_o,
    output logic [BAND_IDX_W-1:0]       band_idx,
    output logic [GROUP_W-1:0]          group_num_o,
    output logic                        do_en,
    input  logic                        o_ready,
    output logic                        is_first_out,
    output logic                        is_last_out,
    output logic                        busy,
    output logic                        overflow
);

    localparam mel_band_idx_t LAST_BAND = BAND_IDX_W'(N_BANDS - 1);

    ser_state_e    state_q, state_d;
    mel_band_idx_t band_q, band_d;

    mel_frame_t    head_frame;
    mel_group_t    head_group;
    logic          next_vld;
    logic [1:0]    cnt;
    logic          accept;
    logic          last_band;
    logic          frame_done;

    assign accept     = do_en && o_ready;
    assign last_band  = (band_q == LAST_BAND);
    assign frame_done = accept && last_band;

    mel_frame_buf u_buf (
        .clk          (clk),
        .rst          (rst),
        .wr_en_i      (di_en),
        .wr_frame_i   (data_i),
        .wr_group_i   (in_group_num),
        .rd_done_i    (frame_done),
        .head_frame_o (head_frame),
        .head_group_o (head_group),
        .next_vld_o   (next_vld),
        .cnt_o        (cnt),
        .overflow_o   (overflow)
    );

    always_comb begin
        state_d = state_q;
        band_d  = band_q;
        case (state_q)
            ST_IDLE: begin
                if (cnt != 2'd0) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    if (last_band) begin
                        band_d = '0;
                        if (!next_vld) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        band_d = band_q + BAND_IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                band_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            band_q  <= '0;
        end else begin
            state_q <= state_d;
            band_q  <= band_d;
        end
    end

    // Outputs decode registered state only; gating keeps them zero while idle.
    assign do_en        = (state_q == ST_STREAM);
    assign data_o       = do_en ? band_of(head_frame, band_q) : '0;
    assign group_num_o  = do_en ? head_group : '0;
    assign band_idx     = band_q;
    assign is_first_out = do_en && (band_q == '0);
    assign is_last_out  = do_en && last_band;
    assign busy         = (cnt != 2'd0);

endmodule

// File: tb/tb_mel_band_serializer.sv
// Directed self-checking bench for mel_band_serializer: table-driven overflow fill plus hand-written sequences.
module tb_mel_band_serializer;
    import mel_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [O_BW*N_BANDS-1:0] data_i;
    logic                    di_en;
    logic [GROUP_W-1:0]      in_group_num;
    mel_sample_t             data_o;
    logic [BAND_IDX_W-1:0]   band_idx;
    logic [GROUP_W-1:0]      group_num_o;
    logic                    do_en;
    logic                    o_ready;
    logic                    is_first_out;
    logic                    is_last_out;
    logic                    busy;
    logic                    overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mel_band_serializer dut (
        .clk          (clk),
        .rst          (rst),
        .data_i       (data_i),
        .di_en        (di_en),
        .in_group_num (in_group_num),
        .data_o       (data_o),
        .band_idx     (band_idx),
        .group_num_o  (group_num_o),
        .do_en        (do_en),
        .o_ready      (o_ready),
        .is_first_out (is_first_out),
        .is_last_out  (is_last_out),
        .busy         (busy),
        .overflow     (overflow)
    );

    typedef struct {
        logic di;
        int   grp;
        logic rdy;
        logic exp_do_en;
        int   exp_band;
        int   exp_grp;
        logic exp_busy;
        logic exp_ovf;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic mel_frame_t mk_frame(input int base, input bit neg);
        mel_frame_t f;
        f = '0;
        for (int k = 0; k < N_BANDS; k++) begin
            mel_sample_t s;
            s = neg ? mel_sample_t'(-k) : mel_sample_t'(base + k);
            f[O_BW*k +: O_BW] = s;
        end
        return f;
    endfunction

    function automatic int val(input int g, input int k);
        return g * 100 + k;
    endfunction

    task automatic send(input int g);
        data_i       = mk_frame(g * 100, 1'b0);
        in_group_num = GROUP_W'(g);
        di_en        = 1'b1;
        step();
        di_en        = 1'b0;
    endtask

    // Expects an uninterrupted run: frame g0 from band b0, then optionally all of frame g1, then idle.
    task automatic drain(input int g0, input int b0, input int g1);
        int n;
        n = (N_BANDS - b0) + ((g1 >= 0) ? N_BANDS : 0);
        o_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            int g;
            int k;
            if (b0 + i < N_BANDS) begin
                g = g0;
                k = b0 + i;
            end else begin
                g = g1;
                k = b0 + i - N_BANDS;
            end
            check("drain_do_en", int'(do_en), 1);
            check("drain_group", int'(group_num_o), g);
            check("drain_band", int'(band_idx), k);
            check("drain_data", int'(data_o), val(g, k));
            check("drain_first", int'(is_first_out), (k == 0) ? 1 : 0);
            check("drain_last", int'(is_last_out), (k == N_BANDS - 1) ? 1 : 0);
            step();
        end
        check("drain_end_do_en", int'(do_en), 0);
        check("drain_end_busy", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [5];
        int   e;
        int   cyc;

        vt[0] = '{1'b1, 1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0};
        vt[1] = '{1'b1, 2, 1'b0, 1'b1, 0, 1, 1'b1, 1'b0};
        vt[2] = '{1'b1, 3, 1'b0, 1'b1, 0, 1, 1'b1, 1'b1};
        vt[3] = '{1'b0, 0, 1'b0, 1'b1, 0, 1, 1'b1, 1'b0};
        vt[4] = '{1'b0, 0, 1'b1, 1'b1, 1, 1, 1'b1, 1'b0};

        rst          = 1'b1;
        di_en        = 1'b0;
        o_ready      = 1'b1;
        data_i       = '0;
        in_group_num = '0;
        step();
        step();
        check("rst_do_en", int'(do_en), 0);
        check("rst_data", int'(data_o), 0);
        check("rst_band", int'(band_idx), 0);
        check("rst_group", int'(group_num_o), 0);
        check("rst_first", int'(is_first_out), 0);
        check("rst_last", int'(is_last_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ovf", int'(overflow), 0);
        rst = 1'b0;
        step();
        check("post_rst_do_en", int'(do_en), 0);

        // Single frame, bands 100+k, group 5
        data_i       = mk_frame(100, 1'b0);
        in_group_num = GROUP_W'(5);
        di_en        = 1'b1;
        step();
        di_en = 1'b0;
        check("single_capture_do_en", int'(do_en), 0);
        check("single_capture_busy", int'(busy), 1);
        step();
        for (int k = 0; k < N_BANDS; k++) begin
            check("single_do_en", int'(do_en), 1);
            check("single_data", int'(data_o), 100 + k);
            check("single_band", int'(band_idx), k);
            check("single_group", int'(group_num_o), 5);
            check("single_first", int'(is_first_out), (k == 0) ? 1 : 0);
            check("single_last", int'(is_last_out), (k == N_BANDS - 1) ? 1 : 0);
            step();
        end
        check("single_end_do_en", int'(do_en), 0);
        check("single_end_busy", int'(busy), 0);

        // Backpressure: o_ready alternates starting high, bands -k
        data_i       = mk_frame(0, 1'b1);
        in_group_num = GROUP_W'(9);
        di_en        = 1'b1;
        step();
        di_en = 1'b0;
        step();
        e   = 0;
        cyc = 0;
        while (e < N_BANDS && cyc < 300) begin
            o_ready = (cyc % 2 == 0);
            check("bp_do_en", int'(do_en), 1);
            check("bp_data", int'(data_o), -e);
            check("bp_band", int'(band_idx), e);
            check("bp_group", int'(group_num_o), 9);
            if (o_ready) e++;
            step();
            cyc++;
        end
        check("bp_cycles", cyc, 127);
        check("bp_end_do_en", int'(do_en), 0);
        o_ready = 1'b1;

        // Back-to-back: frames 1 and 2 three cycles apart
        send(1);
        step();
        step();
        send(2);
        drain(1, 2, 2);

        // Overflow fill phase from the table, then release
        for (int i = 0; i < 5; i++) begin
            data_i       = mk_frame(vt[i].grp * 100, 1'b0);
            in_group_num = GROUP_W'(vt[i].grp);
            di_en        = vt[i].di;
            o_ready      = vt[i].rdy;
            step();
            check("ovf_tbl_do_en", int'(do_en), int'(vt[i].exp_do_en));
            check("ovf_tbl_band", int'(band_idx), vt[i].exp_band);
            check("ovf_tbl_group", int'(group_num_o), vt[i].exp_grp);
            check("ovf_tbl_busy", int'(busy), int'(vt[i].exp_busy));
            check("ovf_tbl_ovf", int'(overflow), int'(vt[i].exp_ovf));
        end
        di_en = 1'b0;
        drain(1, 1, 2);

        // Full buffer with last band accepted in the same cycle as a new frame
        o_ready = 1'b0;
        send(4);
        send(5);
        check("full_do_en", int'(do_en), 1);
        check("full_group", int'(group_num_o), 4);
        o_ready = 1'b1;
        repeat (N_BANDS - 1) step();
        check("full_at_last_band", int'(band_idx), N_BANDS - 1);
        send(6);
        check("full_cmpl_ovf", int'(overflow), 0);
        check("full_cmpl_busy", int'(busy), 1);
        drain(5, 0, 6);

        // Reset mid-stream at band 30 with a second frame buffered
        send(7);
        step();
        send(8);
        repeat (29) step();
        check("mid_band30", int'(band_idx), 30);
        check("mid_group", int'(group_num_o), 7);
        rst          = 1'b1;
        data_i       = mk_frame(900, 1'b0);
        in_group_num = GROUP_W'(9);
        di_en        = 1'b1;
        step();
        check("mid_rst_do_en", int'(do_en), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_band", int'(band_idx), 0);
        rst   = 1'b0;
        di_en = 1'b0;
        step();
        check("rst_di_not_captured", int'(busy), 0);
        check("rst_di_do_en", int'(do_en), 0);
        send(10);
        check("after_rst_capture_busy", int'(busy), 1);
        step();
        drain(10, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mel_band_serializer.md
# mel_band_serializer

Output-side consumer for `mel_filter`. It captures each packed 64-band mel frame, which `mel_filter` presents as one wide word on a `do_en` pulse, and streams the bands out one per cycle under a valid/ready handshake. It carries frame number and band index with each band for the downstream log stage. A two-slot frame buffer absorbs a new frame while the previous one is still draining.

## Interface
- `O_BW`, 14, width of one signed mel band sample
- `N_BANDS`, 64, bands per frame; power of two
- `GROUP_W`, 7, frame-number width (frames 0-88)
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous reset, active-high
- `data_i`  in  O_BW*N_BANDS  packed frame; band k = `data_i[O_BW*k +: O_BW]`
- `di_en`  in  1  frame valid strobe, one cycle per frame
- `in_group_num`  in  GROUP_W  frame number accompanying `data_i`
- `data_o`  out  O_BW  signed band sample
- `band_idx`  out  log2(N_BANDS)  band index of `data_o`
- `group_num_o`  out  GROUP_W  frame number of `data_o`
- `do_en`  out  1  output valid
- `o_ready`  in  1  downstream accepts when `do_en && o_ready`
- `is_first_out`  out  1  `band_idx == 0` while `do_en`
- `is_last_out`  out  1  `band_idx == N_BANDS-1` while `do_en`
- `busy`  out  1  at least one slot occupied
- `overflow`  out  1  one-cycle pulse: incoming frame dropped

## Operation
- Two slots, each holding a frame word and its group number, with a valid bit.
  - Write pointer `wp` and read pointer `rp` are 1 bit each.
  - Occupancy count `cnt` is 0..2.
- Capture: on `di_en` with `cnt < 2`, or with `cnt == 2` and the last band being accepted this cycle, write slot[`wp`], toggle `wp`, and increment `cnt`. The same-cycle read completion decrements `cnt`, so net `cnt` is unchanged in that case.
- Drop: on `di_en` with `cnt == 2` and no same-cycle frame completion, the frame is discarded, `overflow` pulses for 1 cycle, and slot contents are untouched.
- FSM states IDLE and STREAM.
  - IDLE: `do_en = 0`. Go to STREAM when `cnt > 0`.
  - STREAM: `do_en = 1`, `data_o` = slot[`rp`] band `band_idx`.
  - On accept with `band_idx < N_BANDS-1`: increment `band_idx`.
  - On accept with `band_idx == N_BANDS-1`: set `band_idx` to 0, toggle `rp`, decrement `cnt`. Stay in STREAM if the other slot is valid (back-to-back frames, no bubble); otherwise go to IDLE.
- `do_en` low with `o_ready` high has no effect. While `do_en` is high and `o_ready` is low, all outputs hold stable.
- Samples pass through bit-exact; there is no arithmetic or sign change.

## Timing
- Reset values: `data_o = 0`, `band_idx = 0`, `group_num_o = 0`, `do_en = 0`, `is_first_out = 0`, `is_last_out = 0`, `busy = 0`, `overflow = 0`. `wp`, `rp`, and `cnt` reset to 0 and slot valids clear.
- Latency: `di_en` at edge N into an empty block gives `do_en = 1` with band 0 at edge N+1 (registered outputs).
- Throughput: one band per cycle with `o_ready` held high. One frame takes `N_BANDS` cycles.
- `rst` mid-stream: the partial frame and the buffered frame are discarded. `do_en` is low the cycle after `rst`.
- `di_en` coinciding with `rst`: reset wins and the frame is not captured.
- `di_en` into an empty block while idle: the frame is captured and streaming starts next cycle. There is no bypass path.

## Structure
- Shared package `mel_pkg`:
  - `N_BANDS`, `O_BW`, `GROUP_W`, `BAND_IDX_W = $clog2(N_BANDS)`
  - typedef `mel_sample_t` (signed `O_BW`)
  - typedef `mel_frame_t` (`O_BW*N_BANDS`)
- Natural sub-module: `mel_frame_buf`, the two-slot buffer with pointers, `cnt`, and drop/accept logic. The top level holds the FSM and the band mux.

## Test plan
- Single frame: bands k = 100+k, `in_group_num = 5`, `o_ready = 1` → 64 consecutive `do_en` cycles, `data_o` 100..163, `band_idx` 0..63, `group_num_o = 5`, `is_first_out` on band 0, `is_last_out` on band 63, then IDLE.
- Backpressure: toggle `o_ready` every other cycle on a frame with band k = -k → each sample accepted exactly once, outputs stable while stalled, 127 cycles to drain.
- Back-to-back: frames 1 and 2 arrive 3 cycles apart → frame 2 band 0 follows frame 1 band 63 on the next cycle, with no gap.
- Overflow: `o_ready = 0`, three frames (groups 1, 2, 3) → `overflow` pulses on the third, then release yields groups 1 and 2 only.
- Full plus completion: `cnt = 2`, last band accepted in the same cycle as `di_en` → no overflow, new frame streamed third.
- Reset mid-stream at band 30 → next cycle `do_en = 0`, `busy = 0`. A following frame starts at band 0.
